// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
//   Shared constants and types for the register-file writeback arbiter.
//   XLEN / NREG / REG_IDX_W : register file geometry
//   state_t                 : arbiter top-level state (INIT clear, RUN)
//   src_t                   : writeback source identity (A = ALU, B = load)
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter. Grant is combinational from req and the
//   priority pointer; the pointer moves to the non-granted source on each
//   edge where advance is high and a grant was issued.
//
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high, pointer returns to source A
//   req[1:0] in   request vector, bit 0 = A, bit 1 = B
//   advance  in   allow the pointer to move this edge
//   gnt[1:0] out  one-hot grant (or zero when nothing requested)
//   ptr      out  current priority pointer (0 = A, 1 = B)
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);
    import rf_pkg::*;

    src_t       r_ptr;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = '0;
        case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_ptr == SRC_B) ? 2'b10 : 2'b01;
            default: w_gnt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= SRC_A;
        end else if (advance && (|w_gnt)) begin
            // Whoever just won drops to lowest priority.
            r_ptr <= w_gnt[0] ? SRC_B : SRC_A;
        end
    end

    assign gnt = w_gnt;
    assign ptr = r_ptr;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Sole owner of the register file write port. After reset it clears
//   x1..x31 to INIT_VALUE (unless INIT_ENABLE = 0), then arbitrates between
//   the ALU (A) and load (B) writeback requesters with round-robin priority.
//   All rf_* outputs are registered: a write accepted at edge N is presented
//   during the following cycle and committed by the register file at N+1.
//
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high
//   a_valid/a_rd/a_data  in   ALU writeback request
//   a_ready      out  ALU request accepted at the coming edge
//   b_valid/b_rd/b_data  in   load writeback request
//   b_ready      out  load request accepted at the coming edge
//   rf_rd        out  register file write index
//   rf_wdata     out  register file write data
//   rf_regwrite  out  register file write enable
//   init_done    out  high while in RUN
//   grant_b      out  current rf_* write came from source B
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     NREG        = 32,
    parameter bit              INIT_ENABLE = 1'b1,
    parameter logic [XLEN-1:0] INIT_VALUE  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           a_valid,
    input  logic [rf_pkg::REG_IDX_W-1:0]   a_rd,
    input  logic [XLEN-1:0]                a_data,
    output logic                           a_ready,
    input  logic                           b_valid,
    input  logic [rf_pkg::REG_IDX_W-1:0]   b_rd,
    input  logic [XLEN-1:0]                b_data,
    output logic                           b_ready,
    output logic [rf_pkg::REG_IDX_W-1:0]   rf_rd,
    output logic [XLEN-1:0]                rf_wdata,
    output logic                           rf_regwrite,
    output logic                           init_done,
    output logic                           grant_b
);
    import rf_pkg::*;

    localparam logic [REG_IDX_W-1:0] LAST_REG = REG_IDX_W'(NREG - 1);

    state_t                 r_state;
    logic [REG_IDX_W-1:0]   r_init_cnt;
    logic [REG_IDX_W-1:0]   r_rf_rd;
    logic [XLEN-1:0]        r_rf_wdata;
    logic                   r_rf_regwrite;
    logic                   r_grant_b;

    logic                   w_run;
    logic                   w_arb_en;
    logic [1:0]             w_req;
    logic [1:0]             w_gnt;
    logic                   w_rr_ptr;
    logic                   w_any_gnt;
    logic [REG_IDX_W-1:0]   w_sel_rd;
    logic [XLEN-1:0]        w_sel_data;

    assign w_run    = (r_state == RUN);
    // Requests are masked while reset is high so nothing is acknowledged
    // that the reset edge would then discard.
    assign w_arb_en = w_run && !reset;
    assign w_req    = {b_valid, a_valid} & {2{w_arb_en}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req),
        .advance (w_arb_en),
        .gnt     (w_gnt),
        .ptr     (w_rr_ptr)
    );

    assign w_any_gnt  = |w_gnt;
    assign w_sel_rd   = w_gnt[1] ? b_rd   : a_rd;
    assign w_sel_data = w_gnt[1] ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= INIT_ENABLE ? INIT : RUN;
            r_init_cnt    <= REG_IDX_W'(1);
            r_rf_regwrite <= 1'b0;
            r_rf_rd       <= '0;
            r_rf_wdata    <= '0;
            r_grant_b     <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_rf_regwrite <= 1'b1;
                    r_rf_rd       <= r_init_cnt;
                    r_rf_wdata    <= INIT_VALUE;
                    r_grant_b     <= 1'b0;
                    r_init_cnt    <= r_init_cnt + REG_IDX_W'(1);
                    // The last clear write and the move to RUN share an
                    // edge, so init_done is already high while x31 is
                    // being presented.
                    if (r_init_cnt == LAST_REG) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_any_gnt) begin
                        r_rf_rd       <= w_sel_rd;
                        r_rf_wdata    <= w_sel_data;
                        // x0 writes are acknowledged but never committed.
                        r_rf_regwrite <= (w_sel_rd != '0);
                        r_grant_b     <= w_gnt[1];
                    end else begin
                        r_rf_regwrite <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign a_ready     = w_gnt[0];
    assign b_ready     = w_gnt[1];
    assign rf_rd       = r_rf_rd;
    assign rf_wdata    = r_rf_wdata;
    assign rf_regwrite = r_rf_regwrite;
    assign init_done   = w_run;
    assign grant_b     = r_grant_b;

    // Sanity: one grant at a time, and contention is settled by the pointer.
    always_comb begin
        assert (!(a_ready && b_ready));
        if (w_arb_en && a_valid && b_valid) begin
            assert (b_ready == (w_rr_ptr == SRC_B));
        end
    end

endmodule
